// File: rtl/ifid_pipe_stage.sv
// IF/ID pipeline stage between fetch and decode.
// Carries the fetched instruction and its PC+4 to decode through a
// valid/ready handshake, so decode can stall fetch. Flush squashes
// everything held, for branch and jump redirects.
// SKID=0 builds a single register whose in_ready is combinational.
// SKID=1 adds a second entry so that in_ready comes straight from a flop.
// This breaks the ready path from decode back into fetch.
// Whenever the stage holds nothing, decode sees NOP_INSTR.

module ifid_pipe_stage #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h0000_0000,
    parameter bit                 SKID      = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc_plus4,
    input  logic [DATA_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc_plus4,
    output logic [DATA_W-1:0] out_instr,
    output logic [1:0]        occupancy
);

    // Main register: this is the entry that decode currently sees.
    logic              main_valid;
    logic [ADDR_W-1:0] main_pc;
    logic [DATA_W-1:0] main_instr;

    // Handshake events at the coming rising edge.
    logic accept;
    logic deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = main_valid && out_ready;

    generate
        if (SKID == 1'b0) begin : g_single

            // Room exists when the register is empty or is being drained this cycle.
            assign in_ready  = !main_valid || out_ready;
            assign occupancy = {1'b0, main_valid};

            // Single register: load on accept, go empty on a delivery with no refill.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    main_valid <= 1'b0;
                    main_pc    <= '0;
                    main_instr <= NOP_INSTR;
                end else if (Flush) begin
                    main_valid <= 1'b0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_pc    <= in_pc_plus4;
                    main_instr <= in_instr;
                end else if (deliver) begin
                    main_valid <= 1'b0;
                end
            end

        end else begin : g_skid

            // The skid entry catches the one transfer that arrives while decode is stalled.
            logic              skid_valid;
            logic [ADDR_W-1:0] skid_pc;
            logic [DATA_W-1:0] skid_instr;
            logic              ready_q;

            assign in_ready  = ready_q;
            assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

            // Main and skid registers.
            // ready_q is the registered inverse of the skid occupancy.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    main_valid <= 1'b0;
                    main_pc    <= '0;
                    main_instr <= NOP_INSTR;
                    skid_valid <= 1'b0;
                    skid_pc    <= '0;
                    skid_instr <= '0;
                    ready_q    <= 1'b1;
                end else if (Flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    ready_q    <= 1'b1;
                end else if (skid_valid) begin
                    // ready_q is low here, so no accept can happen.
                    // The only event is the skid entry moving up into main.
                    if (deliver) begin
                        main_pc    <= skid_pc;
                        main_instr <= skid_instr;
                        skid_valid <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end else if (accept) begin
                    if (!main_valid || deliver) begin
                        main_valid <= 1'b1;
                        main_pc    <= in_pc_plus4;
                        main_instr <= in_instr;
                    end else begin
                        skid_valid <= 1'b1;
                        skid_pc    <= in_pc_plus4;
                        skid_instr <= in_instr;
                        ready_q    <= 1'b0;
                    end
                end else if (deliver) begin
                    main_valid <= 1'b0;
                end
            end

        end
    endgenerate

    assign out_valid    = main_valid;
    assign out_pc_plus4 = main_pc;

    // A bubble is presented as a NOP so decode never sees stale instruction bits.
    always_comb begin
        out_instr = NOP_INSTR;
        if (main_valid) begin
            out_instr = main_instr;
        end
    end

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// Testbench for ifid_pipe_stage.
// A SKID=0 instance and a SKID=1 instance share one stimulus stream.
// A queue-based model of the entries in flight is kept for each instance.

module tb_ifid_pipe_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        rdy0, vld0, rdy1, vld1;
    logic [31:0] pc0, ins0, pc1, ins1;
    logic [1:0]  occ0, occ1;

    ifid_pipe_stage #(.DATA_W(32), .ADDR_W(32), .NOP_INSTR(NOP), .SKID(1'b0)) dut0 (
        .Clk(clk), .Reset(reset), .Flush(flush),
        .in_valid(in_valid), .in_ready(rdy0),
        .in_pc_plus4(in_pc), .in_instr(in_instr),
        .out_valid(vld0), .out_ready(out_ready),
        .out_pc_plus4(pc0), .out_instr(ins0), .occupancy(occ0)
    );

    ifid_pipe_stage #(.DATA_W(32), .ADDR_W(32), .NOP_INSTR(NOP), .SKID(1'b1)) dut1 (
        .Clk(clk), .Reset(reset), .Flush(flush),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_pc_plus4(in_pc), .in_instr(in_instr),
        .out_valid(vld1), .out_ready(out_ready),
        .out_pc_plus4(pc1), .out_instr(ins1), .occupancy(occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic        ev;
        logic [31:0] einstr;
        logic [31:0] epc;
        logic [1:0]  eocc;
        logic        erdy;
    } vec_t;

    // Model: entries accepted but not yet delivered, oldest first.
    entry_t      q0[$];
    entry_t      q1[$];
    logic [31:0] lastpc0;
    logic [31:0] lastpc1;

    int errors = 0;
    int checks = 0;

    vec_t vecs[23];

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic [31:0] pc,
                                logic [31:0] instr, logic ordy, logic ev,
                                logic [31:0] einstr, logic [31:0] epc,
                                logic [1:0] eocc, logic erdy);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy;
        v.ev = ev; v.einstr = einstr; v.epc = epc; v.eocc = eocc; v.erdy = erdy;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(logic rst, logic fl, logic iv, logic [31:0] pc,
                                 logic [31:0] instr, logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
    endtask

    // Advance both models by one rising edge, using the inputs present at that edge.
    task automatic updateModel();
        bit acc;
        acc = in_valid && ((q0.size() == 0) || out_ready);
        if (reset) begin
            q0.delete();
            lastpc0 = 32'h0;
        end else if (flush) begin
            q0.delete();
        end else begin
            if (out_ready && q0.size() > 0) void'(q0.pop_front());
            if (acc) q0.push_back('{in_pc, in_instr});
            if (q0.size() > 0) lastpc0 = q0[0].pc;
        end

        acc = in_valid && (q1.size() < 2);
        if (reset) begin
            q1.delete();
            lastpc1 = 32'h0;
        end else if (flush) begin
            q1.delete();
        end else begin
            if (out_ready && q1.size() > 0) void'(q1.pop_front());
            if (acc) q1.push_back('{in_pc, in_instr});
            if (q1.size() > 0) lastpc1 = q1[0].pc;
        end
    endtask

    // Compare both instances against the model state and the current inputs.
    task automatic checkOutput(string tag);
        logic        ev;
        logic [31:0] ei;
        ev = (q0.size() > 0);
        ei = ev ? q0[0].instr : NOP;
        check({tag, " s0.valid"}, 32'(vld0), 32'(ev));
        check({tag, " s0.instr"}, ins0, ei);
        check({tag, " s0.pc"}, pc0, lastpc0);
        check({tag, " s0.occ"}, 32'(occ0), 32'(q0.size()));
        check({tag, " s0.ready"}, 32'(rdy0), 32'((q0.size() == 0) || out_ready));
        ev = (q1.size() > 0);
        ei = ev ? q1[0].instr : NOP;
        check({tag, " s1.valid"}, 32'(vld1), 32'(ev));
        check({tag, " s1.instr"}, ins1, ei);
        check({tag, " s1.pc"}, pc1, lastpc1);
        check({tag, " s1.occ"}, 32'(occ1), 32'(q1.size()));
        check({tag, " s1.ready"}, 32'(rdy1), 32'(q1.size() < 2));
    endtask

    task automatic runCycle(string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        updateModel();
        #1;
    endtask

    initial begin
        lastpc0 = 32'h0;
        lastpc1 = 32'h0;

        // Rows are checked before the row's edge, so each row's expectations
        // are the result of the rows above it. Expected values refer to the SKID=1 instance.
        vecs[0]  = mk(0,0,0,32'h00,32'h0,       1, 0,NOP,         32'h00,0,1);
        vecs[1]  = mk(0,0,1,32'h04,32'h8C010004,1, 0,NOP,         32'h00,0,1);
        vecs[2]  = mk(0,0,1,32'h08,32'h00221820,1, 1,32'h8C010004,32'h04,1,1);
        vecs[3]  = mk(0,0,1,32'h0C,32'hAC030008,1, 1,32'h00221820,32'h08,1,1);
        vecs[4]  = mk(0,0,0,32'h00,32'h0,       1, 1,32'hAC030008,32'h0C,1,1);
        vecs[5]  = mk(0,0,0,32'h00,32'h0,       1, 0,NOP,         32'h0C,0,1);
        vecs[6]  = mk(0,0,1,32'h10,32'h11111111,0, 0,NOP,         32'h0C,0,1);
        vecs[7]  = mk(0,0,1,32'h14,32'h22222222,0, 1,32'h11111111,32'h10,1,1);
        vecs[8]  = mk(0,0,0,32'h00,32'h0,       0, 1,32'h11111111,32'h10,2,0);
        vecs[9]  = mk(0,0,0,32'h00,32'h0,       1, 1,32'h11111111,32'h10,2,0);
        vecs[10] = mk(0,0,0,32'h00,32'h0,       1, 1,32'h22222222,32'h14,1,1);
        vecs[11] = mk(0,0,0,32'h00,32'h0,       1, 0,NOP,         32'h14,0,1);
        vecs[12] = mk(0,0,1,32'h20,32'hAAAA0001,0, 0,NOP,         32'h14,0,1);
        vecs[13] = mk(0,0,1,32'h24,32'hAAAA0002,0, 1,32'hAAAA0001,32'h20,1,1);
        vecs[14] = mk(0,1,1,32'h28,32'h33333333,0, 1,32'hAAAA0001,32'h20,2,0);
        vecs[15] = mk(0,0,0,32'h00,32'h0,       1, 0,NOP,         32'h20,0,1);
        vecs[16] = mk(0,1,1,32'h2C,32'h44444444,1, 0,NOP,         32'h20,0,1);
        vecs[17] = mk(0,0,0,32'h00,32'h0,       1, 0,NOP,         32'h20,0,1);
        vecs[18] = mk(0,0,1,32'h30,32'h55555555,0, 0,NOP,         32'h20,0,1);
        vecs[19] = mk(1,1,0,32'h00,32'h0,       0, 1,32'h55555555,32'h30,1,1);
        vecs[20] = mk(0,0,1,32'h34,32'h66666666,1, 0,NOP,         32'h00,0,1);
        vecs[21] = mk(0,0,0,32'h00,32'h0,       1, 1,32'h66666666,32'h34,1,1);
        vecs[22] = mk(0,0,0,32'h00,32'h0,       1, 0,NOP,         32'h34,0,1);

        // Reset for two edges, then release.
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 1);
        @(posedge clk); updateModel(); #1;
        @(posedge clk); updateModel(); #1;

        // Directed table.
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc,
                          vecs[i].instr, vecs[i].ordy);
            @(negedge clk);
            check($sformatf("row%0d valid", i), 32'(vld1), 32'(vecs[i].ev));
            check($sformatf("row%0d instr", i), ins1, vecs[i].einstr);
            check($sformatf("row%0d pc", i), pc1, vecs[i].epc);
            check($sformatf("row%0d occ", i), 32'(occ1), 32'(vecs[i].eocc));
            check($sformatf("row%0d ready", i), 32'(rdy1), 32'(vecs[i].erdy));
            checkOutput($sformatf("row%0d", i));
            @(posedge clk);
            updateModel();
            #1;
        end

        // SKID=0: in_ready follows out_ready within the same cycle.
        applyStimulus(0, 0, 1, 32'h40, 32'h77777777, 0);
        runCycle("comb_load");
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        checkOutput("comb_stall");
        check("comb ready low", 32'(rdy0), 32'h0);
        check("comb held instr", ins0, 32'h77777777);
        out_ready = 1'b1;
        #1;
        check("comb ready high", 32'(rdy0), 32'h1);
        @(posedge clk); updateModel(); #1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        runCycle("comb_drain");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 39) == 0,
                          $urandom_range(0, 15) == 0,
                          1'($urandom_range(0, 1)),
                          $urandom, $urandom,
                          $urandom_range(0, 9) < 6);
            runCycle($sformatf("rnd%0d", n));
        end

        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
        runCycle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
